// File: rtl/stream_sink_checker.sv
// Stream sink checker: accepts a run of words under a selectable back-pressure
// pattern, compares them against an incrementing reference and reports the
// word count, the saturating error count and the first mismatch.
module stream_sink_checker #(
  parameter int unsigned bits      = 32,
  parameter logic [15:0] lfsr_seed = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     num_words,
  input  logic [1:0]      ready_mode,
  input  logic [bits-1:0] upstream_data,
  input  logic            upstream_valid,
  output logic            upstream_ready,
  output logic [31:0]     word_count,
  output logic [15:0]     error_count,
  output logic [bits-1:0] first_err_exp,
  output logic [bits-1:0] first_err_got,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [31:0]     num_q;
  logic [31:0]     word_count_q;
  logic [15:0]     error_count_q;
  logic [bits-1:0] expected_q;
  logic [bits-1:0] first_exp_q;
  logic [bits-1:0] first_got_q;
  logic [15:0]     lfsr_q;
  logic [15:0]     lfsr_nx;
  logic            ready_q;
  logic            done_q;

  logic            go;
  logic            accept;
  logic            last;
  logic            mismatch;
  logic            ready_start;
  logic            ready_run;

  // Handshake qualifiers and LFSR feedback (x^16+x^14+x^13+x^11+1, shift left)
  always_comb begin
    go       = start && (state != RUN);
    accept   = (state == RUN) && upstream_valid && ready_q;
    last     = accept && ((word_count_q + 32'd1) == num_q);
    mismatch = accept && (upstream_data != expected_q);
    lfsr_nx  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Ready value for the first RUN cycle and for each following RUN cycle;
  // the LFSR choice always tracks the LFSR value current in that cycle
  always_comb begin
    ready_start = 1'b0;
    ready_run   = 1'b0;
    case (ready_mode)
      2'd0: begin
        ready_start = 1'b1;
        ready_run   = 1'b1;
      end
      2'd1: begin
        ready_start = 1'b0;
        ready_run   = 1'b0;
      end
      2'd2: begin
        ready_start = 1'b1;
        ready_run   = ~ready_q;
      end
      default: begin
        ready_start = lfsr_seed[0];
        ready_run   = lfsr_nx[0];
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; start is ignored while a run is in progress
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = (num_words == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Run datapath: counters, reference value, first-mismatch capture, LFSR, ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num_q         <= '0;
      word_count_q  <= '0;
      error_count_q <= '0;
      expected_q    <= '0;
      first_exp_q   <= '0;
      first_got_q   <= '0;
      lfsr_q        <= lfsr_seed;
      ready_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go) begin
        num_q         <= num_words;
        word_count_q  <= '0;
        error_count_q <= '0;
        expected_q    <= '0;
        first_exp_q   <= '0;
        first_got_q   <= '0;
        lfsr_q        <= lfsr_seed;
        ready_q       <= (num_words != 32'd0) ? ready_start : 1'b0;
        done_q        <= (num_words == 32'd0);
      end else if (state == RUN) begin
        lfsr_q <= lfsr_nx;
        if (accept) begin
          word_count_q <= word_count_q + 32'd1;
          expected_q   <= expected_q + bits'(1);
        end
        if (mismatch) begin
          if (error_count_q != 16'hFFFF) begin
            error_count_q <= error_count_q + 16'd1;
          end
          if (error_count_q == 16'd0) begin
            first_exp_q <= expected_q;
            first_got_q <= upstream_data;
          end
        end
        // The final acceptance drops ready for the first DONE cycle
        if (last) begin
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          ready_q <= ready_run;
        end
      end else begin
        ready_q <= 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    busy           = (state == RUN);
    done           = done_q;
    upstream_ready = ready_q;
    word_count     = word_count_q;
    error_count    = error_count_q;
    first_err_exp  = first_exp_q;
    first_err_got  = first_got_q;
  end

endmodule
